// File: rtl/btn_debounce_sync_if.sv
// Button bundle between the pad conditioning stage and its consumer:
// raw pad levels in, debounced level and single-cycle press/release events out.
interface btn_debounce_sync_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/btn_debounce_sync.sv
// Per-button 2-FF synchroniser, counter-qualified debounce FSM and press/release pulses.
// Optional auto-repeat on held buttons is enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce_sync #(
    parameter int               N_BTN                = 3,
    parameter int               DEBOUNCE_CYCLES      = 250000,
    parameter int               CNT_W                = 18,
    parameter logic [N_BTN-1:0] REPEAT_MASK          = 3'b110,
    parameter int               REPEAT_DELAY_CYCLES  = 25000000,
    parameter int               REPEAT_PERIOD_CYCLES = 5000000,
    parameter int               RPT_W                = 25
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    btn_debounce_sync_if.slave         btn_if
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM_P   = 2'd1,
        PRESSED = 2'd2,
        ARM_R   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] meta_r;
    logic [N_BTN-1:0] sync_r;

    state_t           state_r [N_BTN];
    state_t           state_s [N_BTN];
    logic [CNT_W-1:0] cnt_r   [N_BTN];
    logic [CNT_W-1:0] cnt_s   [N_BTN];
    logic [N_BTN-1:0] level_r;
    logic [N_BTN-1:0] level_s;
    logic [N_BTN-1:0] press_r;
    logic [N_BTN-1:0] press_s;
    logic [N_BTN-1:0] release_r;
    logic [N_BTN-1:0] release_s;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY_CYCLES - REPEAT_PERIOD_CYCLES);

    logic [RPT_W-1:0] rpt_r [N_BTN];
    logic [RPT_W-1:0] rpt_s [N_BTN];
`else
    logic unused_rpt_cfg_s;
    assign unused_rpt_cfg_s = ^{REPEAT_MASK, 32'(REPEAT_DELAY_CYCLES),
                                32'(REPEAT_PERIOD_CYCLES), 32'(RPT_W)};
`endif

    // Two-stage synchroniser; it keeps sampling even while the block is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {N_BTN{1'b0}};
            sync_r <= {N_BTN{1'b0}};
        end else begin
            meta_r <= btn_if.btn_raw;
            sync_r <= meta_r;
        end
    end

    // Next-state, counter and pulse logic for every channel.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_s[i]   = state_r[i];
            cnt_s[i]     = cnt_r[i];
            level_s[i]   = level_r[i];
            press_s[i]   = 1'b0;
            release_s[i] = 1'b0;

            if (!ena) begin
                state_s[i] = IDLE;
                cnt_s[i]   = {CNT_W{1'b0}};
                level_s[i] = 1'b0;
            end else begin
                case (state_r[i])
                    IDLE: begin
                        level_s[i] = 1'b0;
                        cnt_s[i]   = {CNT_W{1'b0}};
                        if (sync_r[i]) begin
                            state_s[i] = ARM_P;
                        end else begin
                            state_s[i] = IDLE;
                        end
                    end
                    ARM_P: begin
                        if (!sync_r[i]) begin
                            state_s[i] = IDLE;
                            cnt_s[i]   = {CNT_W{1'b0}};
                        end else if (cnt_r[i] == DB_LAST) begin
                            state_s[i] = PRESSED;
                            cnt_s[i]   = {CNT_W{1'b0}};
                            press_s[i] = 1'b1;
                            level_s[i] = 1'b1;
                        end else begin
                            cnt_s[i] = cnt_r[i] + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        level_s[i] = 1'b1;
                        cnt_s[i]   = {CNT_W{1'b0}};
                        if (!sync_r[i]) begin
                            state_s[i] = ARM_R;
                        end else begin
                            state_s[i] = PRESSED;
                        end
                    end
                    ARM_R: begin
                        // A level that returns high mid-qualification is treated as bounce.
                        if (sync_r[i]) begin
                            state_s[i] = PRESSED;
                            cnt_s[i]   = {CNT_W{1'b0}};
                        end else if (cnt_r[i] == DB_LAST) begin
                            state_s[i]   = IDLE;
                            cnt_s[i]     = {CNT_W{1'b0}};
                            release_s[i] = 1'b1;
                            level_s[i]   = 1'b0;
                        end else begin
                            cnt_s[i] = cnt_r[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_s[i] = IDLE;
                        cnt_s[i]   = {CNT_W{1'b0}};
                        level_s[i] = 1'b0;
                    end
                endcase
            end

`ifdef BTN_AUTOREPEAT_EN
            // Repeat timer runs across PRESSED and ARM_R dwell; a qualifying release wins.
            rpt_s[i] = {RPT_W{1'b0}};
            if (ena && REPEAT_MASK[i] && (state_s[i] != IDLE) &&
                ((state_r[i] == PRESSED) || (state_r[i] == ARM_R))) begin
                if (rpt_r[i] == RPT_FIRST) begin
                    rpt_s[i]   = RPT_RELOAD;
                    press_s[i] = 1'b1;
                end else begin
                    rpt_s[i] = rpt_r[i] + RPT_W'(1);
                end
            end else begin
                rpt_s[i] = {RPT_W{1'b0}};
            end
`endif
        end
    end

    // State, counter and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_r[i] <= IDLE;
                cnt_r[i]   <= {CNT_W{1'b0}};
`ifdef BTN_AUTOREPEAT_EN
                rpt_r[i]   <= {RPT_W{1'b0}};
`endif
            end
            level_r   <= {N_BTN{1'b0}};
            press_r   <= {N_BTN{1'b0}};
            release_r <= {N_BTN{1'b0}};
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
`ifdef BTN_AUTOREPEAT_EN
                rpt_r[i]   <= rpt_s[i];
`endif
            end
            level_r   <= level_s;
            press_r   <= press_s;
            release_r <= release_s;
        end
    end

    assign btn_if.btn_level   = level_r;
    assign btn_if.btn_press   = press_r;
    assign btn_if.btn_release = release_r;

endmodule
